// File: rtl/sdram_pkg.sv
// Shared SDRAM constants: command encodings and refresh timing defaults,
// reused by the init, read, write, refresh and arbiter blocks.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;

  localparam int REF_INTERVAL = 780;  // 7.8 us at 100 MHz
  localparam int T_RP         = 2;
  localparam int T_RC         = 7;

  typedef enum logic {
    REF_IDLE,
    REF_BUSY
  } refresh_state_t;

endpackage

// File: rtl/sdram_refresh_ctrl_if.sv
// Refresh controller <-> arbiter/SDRAM command bundle.
// The master side is the refresh controller; the slave side is the arbiter.
interface sdram_refresh_ctrl_if;
  logic [3:0] cmd_reg;
  logic       arbit_refresh_req;
  logic       arbit_refresh_ack;
  logic       refresh_end;

  modport master (
    output cmd_reg,
    output arbit_refresh_req,
    output refresh_end,
    input  arbit_refresh_ack
  );

  modport slave (
    input  cmd_reg,
    input  arbit_refresh_req,
    input  refresh_end,
    output arbit_refresh_ack
  );
endinterface

// File: rtl/sdram_refresh_ctrl.sv
// Periodic SDRAM auto-refresh: free-running interval counter raises a request,
// and once granted issues PRECHARGE, AUTO_REFRESH, AUTO_REFRESH, then refresh_end.
module sdram_refresh_ctrl #(
  parameter int REF_INTERVAL = sdram_pkg::REF_INTERVAL,
  parameter int T_RP         = sdram_pkg::T_RP,
  parameter int T_RC         = sdram_pkg::T_RC
) (
  input logic                  sysclk_100M,
  input logic                  rst_n,
  sdram_refresh_ctrl_if.master bus
);
  import sdram_pkg::*;

  localparam int IW      = $clog2(REF_INTERVAL);
  localparam int SEQ_LEN = T_RP + 2 * T_RC;
  localparam int SW      = $clog2(SEQ_LEN + 1);

  localparam logic [IW-1:0] IVL_LAST = IW'(REF_INTERVAL - 1);
  localparam logic [SW-1:0] AR1_AT   = SW'(T_RP);
  localparam logic [SW-1:0] AR2_AT   = SW'(T_RP + T_RC);
  localparam logic [SW-1:0] END_AT   = SW'(SEQ_LEN);

  refresh_state_t state_reg, state_next;
  logic [IW-1:0]  ivl_reg, ivl_next;
  logic [SW-1:0]  seq_reg, seq_next;
  logic           req_reg, req_next;
  logic [3:0]     cmd_out_reg, cmd_out_next;
  logic           end_reg, end_next;
  logic           ivl_wrap;

  assign ivl_wrap = (ivl_reg == IVL_LAST);

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= REF_IDLE;
      ivl_reg     <= '0;
      seq_reg     <= '0;
      req_reg     <= 1'b0;
      cmd_out_reg <= CMD_NOP;
      end_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ivl_reg     <= ivl_next;
      seq_reg     <= seq_next;
      req_reg     <= req_next;
      cmd_out_reg <= cmd_out_next;
      end_reg     <= end_next;
    end
  end

  // seq_reg holds the number of edges since acceptance, so each command is
  // decoded one edge ahead and lands registered in the following cycle.
  always_comb begin
    state_next   = state_reg;
    seq_next     = seq_reg;
    ivl_next     = ivl_wrap ? '0 : ivl_reg + 1'b1;
    req_next     = req_reg | ivl_wrap;
    cmd_out_next = CMD_NOP;
    end_next     = 1'b0;
    case (state_reg)
      REF_IDLE: begin
        // A wrap on the accepting edge is absorbed, never queued.
        if (req_reg && bus.arbit_refresh_ack) begin
          state_next   = REF_BUSY;
          req_next     = 1'b0;
          seq_next     = SW'(1);
          cmd_out_next = CMD_PRECHARGE;
        end
      end
      REF_BUSY: begin
        seq_next = seq_reg + 1'b1;
        if (seq_reg == AR1_AT || seq_reg == AR2_AT) begin
          cmd_out_next = CMD_AUTO_REFRESH;
        end
        if (seq_reg == END_AT) begin
          state_next = REF_IDLE;
          seq_next   = '0;
          end_next   = 1'b1;
        end
      end
      default: state_next = REF_IDLE;
    endcase
  end

  assign bus.cmd_reg           = cmd_out_reg;
  assign bus.arbit_refresh_req = req_reg;
  assign bus.refresh_end       = end_reg;

endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
// Self-checking bench for sdram_refresh_ctrl: scenario tasks compared cycle by
// cycle against an edge-count/offset model of the refresh schedule.
module tb_sdram_refresh_ctrl;
  import sdram_pkg::*;

  localparam int SEQ_LAST = T_RP + 2 * T_RC;

  logic sysclk_100M = 1'b0;
  logic rst_n       = 1'b0;

  sdram_refresh_ctrl_if bus ();

  sdram_refresh_ctrl #(
    .REF_INTERVAL(REF_INTERVAL),
    .T_RP        (T_RP),
    .T_RC        (T_RC)
  ) dut (
    .sysclk_100M(sysclk_100M),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  always #5 sysclk_100M = ~sysclk_100M;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: edges since reset release, pending request, start edge
  // of the current sequence; outputs follow from the offset into the sequence.
  int         n_edge;
  int         seq_start;
  int         accepts = 0;
  bit         pending;
  bit         in_seq;
  logic [3:0] exp_cmd;
  logic       exp_req;
  logic       exp_end;

  task automatic model_reset();
    n_edge    = 0;
    pending   = 1'b0;
    in_seq    = 1'b0;
    seq_start = 0;
    exp_cmd   = CMD_NOP;
    exp_req   = 1'b0;
    exp_end   = 1'b0;
  endtask

  task automatic model_edge(input bit ack);
    int d;
    bit busy;
    n_edge++;
    busy = in_seq && ((n_edge - seq_start) <= SEQ_LAST);
    if (pending && ack && !busy) begin
      pending   = 1'b0;
      in_seq    = 1'b1;
      seq_start = n_edge;
      accepts++;
      $display("[TB] edge %0d: refresh sequence %0d accepted", n_edge, accepts);
    end else if (n_edge % REF_INTERVAL == 0) begin
      pending = 1'b1;
    end
    d       = in_seq ? (n_edge - seq_start) : -1;
    exp_cmd = CMD_NOP;
    if (d == 0) exp_cmd = CMD_PRECHARGE;
    else if (d == T_RP || d == T_RP + T_RC) exp_cmd = CMD_AUTO_REFRESH;
    exp_end = (d == SEQ_LAST);
    exp_req = pending;
  endtask

  // Drive ack for one clock, advance the model, and settle 1 unit past the edge.
  task automatic cycle(input bit ack);
    bus.arbit_refresh_ack = ack;
    @(posedge sysclk_100M);
    model_edge(ack);
    #1;
  endtask

  task automatic test_reset();
    bus.arbit_refresh_ack = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.arbit_refresh_ack = (i >= 5);
      @(posedge sysclk_100M);
      #1;
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {CMD_NOP, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset cyc %0d: cmd/req/end got %b/%b/%b expected 0111/0/0",
                 i, bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end);
      end
    end
    bus.arbit_refresh_ack = 1'b0;
    rst_n = 1'b1;
    model_reset();
    $display("[TB] reset released");
  endtask

  task automatic test_first_request();
    int rise = -1;
    for (int i = 0; i < REF_INTERVAL + 5; i++) begin
      cycle(1'b0);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL first_req edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
      if (bus.arbit_refresh_req === 1'b1 && rise < 0) rise = n_edge;
    end
    tests_run++;
    if (rise != REF_INTERVAL) begin
      tests_failed++;
      $display("FAIL first_req_edge: req rose at edge %0d expected %0d", rise, REF_INTERVAL);
    end
    $display("[TB] first request observed at edge %0d", rise);
  endtask

  task automatic test_ack_burst();
    int pre_e = -1, ar1_e = -1, ar2_e = -1, end_e = -1;
    int n_pre = 0, n_ar = 0, n_end = 0;
    int acc0;
    for (int i = 0; i < 200 && n_edge < REF_INTERVAL + 11; i++) begin
      cycle(1'b0);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL burst_wait edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
    end
    acc0 = accepts;
    for (int i = 0; i < 20; i++) begin
      cycle(i < 8);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL burst edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
      if (bus.cmd_reg === CMD_PRECHARGE) begin n_pre++; pre_e = n_edge; end
      if (bus.cmd_reg === CMD_AUTO_REFRESH) begin
        n_ar++;
        if (ar1_e < 0) ar1_e = n_edge; else ar2_e = n_edge;
      end
      if (bus.refresh_end === 1'b1) begin n_end++; end_e = n_edge; end
    end
    tests_run++;
    if (n_pre != 1 || n_ar != 2 || n_end != 1 || accepts - acc0 != 1) begin
      tests_failed++;
      $display("FAIL burst_counts: pre/ar/end/accepts got %0d/%0d/%0d/%0d expected 1/2/1/1",
               n_pre, n_ar, n_end, accepts - acc0);
    end
    tests_run++;
    if (ar1_e - pre_e != T_RP || ar2_e - pre_e != T_RP + T_RC || end_e - pre_e != SEQ_LAST) begin
      tests_failed++;
      $display("FAIL burst_offsets: ar1/ar2/end offsets got %0d/%0d/%0d expected %0d/%0d/%0d",
               ar1_e - pre_e, ar2_e - pre_e, end_e - pre_e, T_RP, T_RP + T_RC, SEQ_LAST);
    end
  endtask

  task automatic test_no_ack_long();
    int start_n = n_edge;
    int exp_rise = (n_edge / REF_INTERVAL + 1) * REF_INTERVAL;
    int rise = -1, drops = 0, non_nop = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b0);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL no_ack edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
      if (bus.arbit_refresh_req === 1'b1 && rise < 0) rise = n_edge;
      if (rise >= 0 && bus.arbit_refresh_req !== 1'b1) drops++;
      if (bus.cmd_reg !== CMD_NOP) non_nop++;
    end
    tests_run++;
    if (rise != exp_rise || drops != 0 || non_nop != 0) begin
      tests_failed++;
      $display("FAIL no_ack_hold (from edge %0d): rise/drops/cmds got %0d/%0d/%0d expected %0d/0/0",
               start_n, rise, drops, non_nop, exp_rise);
    end
  endtask

  task automatic test_ack_without_req();
    int activity = 0;
    for (int i = 0; i < 171; i++) begin
      // one grant pulse, let the sequence drain, then hold ack with nothing pending
      cycle(i == 0 || i >= 21);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL ack_no_req edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
      if (i >= 21 && (bus.cmd_reg !== CMD_NOP || bus.refresh_end !== 1'b0)) activity++;
    end
    tests_run++;
    if (activity != 0) begin
      tests_failed++;
      $display("FAIL ack_no_req_idle: active cycles got %0d expected 0", activity);
    end
  endtask

  task automatic test_back_to_back();
    int pre_q[$];
    int req_in_busy = 0;
    bit busy_obs = 1'b0;
    for (int i = 0; i < 3 * REF_INTERVAL; i++) begin
      if (pending && (n_edge % REF_INTERVAL == REF_INTERVAL - 10)) break;
      cycle(1'b0);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL b2b_wait edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
    end
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL b2b edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
      if (bus.cmd_reg === CMD_PRECHARGE) begin pre_q.push_back(n_edge); busy_obs = 1'b1; end
      else if (busy_obs && bus.arbit_refresh_req === 1'b1) req_in_busy++;
      if (bus.refresh_end === 1'b1) busy_obs = 1'b0;
    end
    tests_run++;
    if (pre_q.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: sequences got %0d expected 2", pre_q.size());
    end else begin
      tests_run++;
      if (pre_q[1] - pre_q[0] != SEQ_LAST + 1) begin
        tests_failed++;
        $display("FAIL b2b_gap: start spacing got %0d expected %0d", pre_q[1] - pre_q[0], SEQ_LAST + 1);
      end
    end
    tests_run++;
    if (req_in_busy == 0) begin
      tests_failed++;
      $display("FAIL b2b_req_in_busy: req-high busy cycles got 0 expected >0");
    end
  endtask

  task automatic test_reset_mid_seq();
    int rise = -1, hit = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge sysclk_100M);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < REF_INTERVAL + 20; i++) begin
      cycle(pending);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL mid_setup edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
      if (bus.cmd_reg === CMD_AUTO_REFRESH) begin hit = 1; break; end
    end
    tests_run++;
    if (hit == 0) begin
      tests_failed++;
      $display("FAIL mid_reach_ar: AUTO_REFRESH seen got 0 expected 1");
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {CMD_NOP, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_async: cmd/req/end got %b/%b/%b expected 0111/0/0",
               bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end);
    end
    bus.arbit_refresh_ack = 1'b0;
    repeat (2) @(posedge sysclk_100M);
    #1;
    rst_n = 1'b1;
    model_reset();
    $display("[TB] mid-sequence reset released");
    for (int i = 0; i < REF_INTERVAL + 3; i++) begin
      cycle(1'b0);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL mid_after edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
      if (bus.arbit_refresh_req === 1'b1 && rise < 0) rise = n_edge;
    end
    tests_run++;
    if (rise != REF_INTERVAL) begin
      tests_failed++;
      $display("FAIL mid_next_req: req rose at edge %0d expected %0d", rise, REF_INTERVAL);
    end
  endtask

  task automatic test_ack_tied_high();
    int pre_q[$];
    int end_q[$];
    int start_n = n_edge;
    int exp_seq;
    for (int i = 0; i < 2 * REF_INTERVAL + 40; i++) begin
      cycle(1'b1);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL tied edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
      if (bus.cmd_reg === CMD_PRECHARGE) pre_q.push_back(n_edge);
      if (bus.refresh_end === 1'b1) end_q.push_back(n_edge);
    end
    // one request already pending at entry, plus one per wrap crossed
    exp_seq = 1 + (n_edge / REF_INTERVAL - start_n / REF_INTERVAL);
    tests_run++;
    if (pre_q.size() != exp_seq || end_q.size() != exp_seq) begin
      tests_failed++;
      $display("FAIL tied_count: starts/ends got %0d/%0d expected %0d/%0d",
               pre_q.size(), end_q.size(), exp_seq, exp_seq);
    end else begin
      for (int k = 0; k < exp_seq; k++) begin
        tests_run++;
        if (end_q[k] - pre_q[k] != SEQ_LAST) begin
          tests_failed++;
          $display("FAIL tied_len seq %0d: length got %0d expected %0d", k, end_q[k] - pre_q[k], SEQ_LAST);
        end
      end
      for (int k = 2; k < exp_seq; k++) begin
        tests_run++;
        if (pre_q[k] - pre_q[k-1] != REF_INTERVAL) begin
          tests_failed++;
          $display("FAIL tied_period seq %0d: spacing got %0d expected %0d",
                   k, pre_q[k] - pre_q[k-1], REF_INTERVAL);
        end
      end
    end
  endtask

  task automatic test_random();
    int prob = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) prob = $urandom_range(0, 100);
      cycle($urandom_range(0, 99) < prob);
      tests_run++;
      if ({bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end} !== {exp_cmd, exp_req, exp_end}) begin
        tests_failed++;
        $display("FAIL random edge %0d: cmd/req/end got %b/%b/%b expected %b/%b/%b", n_edge,
                 bus.cmd_reg, bus.arbit_refresh_req, bus.refresh_end, exp_cmd, exp_req, exp_end);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_ack_burst();
    test_no_ack_long();
    test_ack_without_req();
    test_back_to_back();
    test_reset_mid_seq();
    test_ack_tied_high();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
